display_capture: RTL and testbench

DISPLAY_CAPTURE -- requirements
Module: display_capture

---
 rtl/display_capture_pkg.sv | 39 +++
 rtl/display_capture_anode_decode.sv | 28 ++
 rtl/display_capture.sv | 168 ++++++++++++++++
 tb/tb_display_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_capture_pkg.sv
// Shared constants, state type and frame helper for the 7-segment display capture block.
package display_capture_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned VALUE_W    = DIGIT_W * NUM_DIGITS;
  localparam int unsigned STAB_W     = 4;
  localparam int unsigned TO_W       = 8;

  localparam int unsigned DEF_STABLE_FRAMES = 2;
  localparam int unsigned DEF_TIMEOUT       = 16;

  localparam logic [3:0] AN0      = 4'b1110;
  localparam logic [3:0] AN1      = 4'b1101;
  localparam logic [3:0] AN2      = 4'b1011;
  localparam logic [3:0] AN3      = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef enum logic [0:0] {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } cap_state_e;

  // Replace the nibble of digit idx inside a frame.
  function automatic logic [VALUE_W-1:0] put_nibble(input logic [VALUE_W-1:0] frame,
                                                    input logic [1:0]         idx,
                                                    input logic [DIGIT_W-1:0] nib);
    logic [VALUE_W-1:0] f;
    f = frame;
    case (idx)
      2'd0:    f[3:0]   = nib;
      2'd1:    f[7:4]   = nib;
      2'd2:    f[11:8]  = nib;
      default: f[15:12] = nib;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/display_capture_anode_decode.sv
// Combinational anode decoder: one-cold pattern -> digit index, plus blank flag.
module anode_decode
  import display_capture_pkg::*;
(
  input  logic [3:0] sel_i,
  output logic       legal_c_o,
  output logic       blank_c_o,
  output logic [1:0] idx_c_o
);

  always_comb begin
    legal_c_o = 1'b1;
    blank_c_o = 1'b0;
    idx_c_o   = 2'd0;
    case (sel_i)
      AN0:      idx_c_o = 2'd0;
      AN1:      idx_c_o = 2'd1;
      AN2:      idx_c_o = 2'd2;
      AN3:      idx_c_o = 2'd3;
      AN_BLANK: begin
        legal_c_o = 1'b0;
        blank_c_o = 1'b1;
      end
      default:  legal_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Reconstructs the 16-bit value shown on a multiplexed 4-digit display and
// publishes it once enough identical frames have been seen.
module display_capture
  import display_capture_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = DEF_STABLE_FRAMES,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic               clk_1k,
  input  logic               reset,
  input  logic [3:0]         digit_select,
  input  logic [DIGIT_W-1:0] binary_num,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               new_value,
  output logic               frame_error
);

  logic [3:0]         sel_q;
  logic [DIGIT_W-1:0] num_q;

  logic               dec_legal;
  logic               dec_blank;
  logic [1:0]         dec_idx;

  cap_state_e         state_q, state_d;
  logic [1:0]         last_idx_q, last_idx_d;
  logic [VALUE_W-1:0] frame_q, frame_d;
  logic               done_q, done_d;
  logic [VALUE_W-1:0] prev_q, prev_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               new_q, new_d;
  logic               ferr_q, ferr_d;
  logic               timeout_hit;

  // Input capture: everything downstream works on these copies only.
  always_ff @(posedge clk_1k) begin
    if (reset) begin
      sel_q <= AN_BLANK;
      num_q <= '0;
    end else begin
      sel_q <= digit_select;
      num_q <= binary_num;
    end
  end

  anode_decode u_decode (
    .sel_i     (sel_q),
    .legal_c_o (dec_legal),
    .blank_c_o (dec_blank),
    .idx_c_o   (dec_idx)
  );

  always_ff @(posedge clk_1k) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      last_idx_q <= 2'd0;
      frame_q    <= '0;
      done_q     <= 1'b0;
      prev_q     <= '0;
      stab_q     <= '0;
      to_q       <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      new_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
      prev_q     <= prev_d;
      stab_q     <= stab_d;
      to_q       <= to_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      new_q      <= new_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    frame_d     = frame_q;
    done_d      = 1'b0;
    prev_d      = prev_q;
    stab_d      = stab_q;
    to_d        = to_q;
    value_d     = value_q;
    valid_d     = valid_q;
    new_d       = 1'b0;
    ferr_d      = 1'b0;
    timeout_hit = 1'b0;

    // Frame assembly; a repeated index means a display slower than our clock.
    case (state_q)
      ST_HUNT: begin
        if (dec_legal && dec_idx == 2'd0) begin
          frame_d    = put_nibble(frame_q, 2'd0, num_q);
          last_idx_d = 2'd0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (dec_legal) begin
          if (dec_idx == last_idx_q) begin
            frame_d = put_nibble(frame_q, dec_idx, num_q);
          end else if (dec_idx == last_idx_q + 2'd1) begin
            frame_d    = put_nibble(frame_q, dec_idx, num_q);
            last_idx_d = dec_idx;
            if (dec_idx == 2'd3) begin
              done_d  = 1'b1;
              state_d = ST_HUNT;
            end
          end else begin
            ferr_d = 1'b1;
            if (dec_idx == 2'd0) begin
              frame_d    = put_nibble(frame_q, 2'd0, num_q);
              last_idx_d = 2'd0;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end else if (!dec_blank) begin
          ferr_d  = 1'b1;
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Stability tracking and publication of a completed frame.
    if (done_q) begin
      if (frame_q == prev_q) begin
        stab_d = (stab_q == STAB_W'(15)) ? stab_q : stab_q + STAB_W'(1);
      end else begin
        stab_d = STAB_W'(1);
        prev_d = frame_q;
      end
      if (stab_d == STAB_W'(STABLE_FRAMES)) begin
        value_d = frame_q;
        valid_d = 1'b1;
        new_d   = (frame_q != value_q) || !valid_q;
      end
    end

    if (dec_legal) begin
      to_d = '0;
    end else if (to_q < TO_W'(TIMEOUT)) begin
      to_d = to_q + TO_W'(1);
    end
    timeout_hit = (to_q != TO_W'(TIMEOUT)) && (to_d == TO_W'(TIMEOUT));
    if (timeout_hit) begin
      valid_d = 1'b0;
      stab_d  = '0;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign new_value   = new_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: expected publications are queued as
// frames are driven and matched against observed new_value pulses.
module tb_display_capture;
  import display_capture_pkg::*;

  logic        clk_1k = 1'b0;
  logic        reset;
  logic        rst1;
  logic [3:0]  digit_select;
  logic [3:0]  binary_num;
  logic [15:0] value, value1;
  logic        value_valid, valid1;
  logic        new_value, new1;
  logic        frame_error, ferr1;

  int n_tests = 0;
  int n_fail  = 0;
  int ferr_cnt  = 0;
  int ferr1_cnt = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp1_q[$];
  logic [15:0] obs1_q[$];

  always #5 clk_1k = ~clk_1k;

  display_capture dut (
    .clk_1k       (clk_1k),
    .reset        (reset),
    .digit_select (digit_select),
    .binary_num   (binary_num),
    .value        (value),
    .value_valid  (value_valid),
    .new_value    (new_value),
    .frame_error  (frame_error)
  );

  display_capture #(.STABLE_FRAMES(1), .TIMEOUT(16)) dut1 (
    .clk_1k       (clk_1k),
    .reset        (rst1),
    .digit_select (digit_select),
    .binary_num   (binary_num),
    .value        (value1),
    .value_valid  (valid1),
    .new_value    (new1),
    .frame_error  (ferr1)
  );

  // Observe pulses away from the active edge.
  always @(negedge clk_1k) begin
    if (new_value)   obs_q.push_back(value);
    if (new1)        obs1_q.push_back(value1);
    if (frame_error) ferr_cnt++;
    if (ferr1)       ferr1_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] an_of(input int d);
    case (d)
      0:       return AN0;
      1:       return AN1;
      2:       return AN2;
      default: return AN3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] sel, input logic [3:0] num);
    digit_select = sel;
    binary_num   = num;
    @(posedge clk_1k);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(AN_BLANK, 4'h0);
  endtask

  task automatic send_frame(input logic [15:0] f, input int hold);
    for (int d = 0; d < 4; d++) begin
      repeat (hold) step(an_of(d), f[4*d +: 4]);
    end
  endtask

  // Match every observed pulse against the scoreboard, in order.
  task automatic drain(input bit which);
    logic [15:0] o;
    logic [15:0] e;
    if (!which) begin
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pulse_value", 32'(o), 32'(e));
        end
      end
    end else begin
      while (obs1_q.size() > 0) begin
        o = obs1_q.pop_front();
        check("pulse1_expected", 32'(exp1_q.size() > 0), 32'd1);
        if (exp1_q.size() > 0) begin
          e = exp1_q.pop_front();
          check("pulse1_value", 32'(o), 32'(e));
        end
      end
    end
  endtask

  initial begin
    logic [15:0] alt [4];
    alt[0] = 16'h1111; alt[1] = 16'h2222; alt[2] = 16'h1111; alt[3] = 16'h2222;
    reset = 1'b1;
    rst1  = 1'b1;
    digit_select = AN_BLANK;
    binary_num   = 4'h0;
    idle(2);
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_new", 32'(new_value), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    reset = 1'b0;
    idle(1);
    check("post_rst_new", 32'(new_value), 32'd0);

    // Repeated 0x1234 frames, one digit per cycle; check two-edge latency.
    send_frame(16'h1234, 1);
    exp_q.push_back(16'h1234);
    send_frame(16'h1234, 1);
    idle(1);
    check("lat_n1_new", 32'(new_value), 32'd0);
    check("lat_n1_value", 32'(value), 32'h0);
    idle(1);
    check("lat_n2_new", 32'(new_value), 32'd1);
    check("s29_value", 32'(value), 32'h1234);
    check("s29_valid", 32'(value_valid), 32'd1);
    idle(1);
    check("s29_pulse_width", 32'(new_value), 32'd0);
    drain(0);
    send_frame(16'h1234, 1);
    idle(2);
    check("s29_third_no_pulse", 32'(new_value), 32'd0);
    idle(1);
    drain(0);
    check("s29_pending", 32'(exp_q.size()), 32'd0);

    // Digit order 0,1,3 is a framing error.
    step(AN0, 4'h9);
    step(AN1, 4'h8);
    step(AN3, 4'h7);
    idle(1);
    check("s30_ferr", 32'(frame_error), 32'd1);
    check("s30_value_hold", 32'(value), 32'h1234);
    idle(1);
    check("s30_ferr_width", 32'(frame_error), 32'd0);
    send_frame(16'hABCD, 1);
    exp_q.push_back(16'hABCD);
    send_frame(16'hABCD, 1);
    idle(3);
    check("s30_value", 32'(value), 32'hABCD);
    drain(0);
    check("s30_pending", 32'(exp_q.size()), 32'd0);

    // Slow display: each digit held three cycles.
    send_frame(16'h0F0F, 3);
    exp_q.push_back(16'h0F0F);
    send_frame(16'h0F0F, 3);
    idle(2);
    check("s31_value", 32'(value), 32'h0F0F);
    check("s31_valid", 32'(value_valid), 32'd1);
    check("s31_ferr_cnt", 32'(ferr_cnt), 32'd1);
    drain(0);
    check("s31_pending", 32'(exp_q.size()), 32'd0);

    // Blank timeout then recovery.
    send_frame(16'h1234, 1);
    exp_q.push_back(16'h1234);
    send_frame(16'h1234, 1);
    idle(16);
    check("s32_valid_before", 32'(value_valid), 32'd1);
    check("s32_value_before", 32'(value), 32'h1234);
    idle(1);
    check("s32_valid_timeout", 32'(value_valid), 32'd0);
    check("s32_value_hold", 32'(value), 32'h1234);
    drain(0);
    send_frame(16'h1234, 1);
    exp_q.push_back(16'h1234);
    send_frame(16'h1234, 1);
    idle(3);
    check("s32_valid_again", 32'(value_valid), 32'd1);
    drain(0);
    check("s32_pending", 32'(exp_q.size()), 32'd0);

    // Illegal anode pattern, then reset in the middle of a frame.
    step(AN0, 4'h1);
    step(AN1, 4'h2);
    step(4'b1100, 4'h3);
    idle(1);
    check("s33_ferr", 32'(frame_error), 32'd1);
    idle(1);
    step(AN0, 4'h5);
    step(AN1, 4'h6);
    reset = 1'b1;
    step(AN2, 4'h7);
    check("s33_rst_value", 32'(value), 32'h0);
    check("s33_rst_valid", 32'(value_valid), 32'd0);
    check("s33_rst_new", 32'(new_value), 32'd0);
    check("s33_rst_ferr", 32'(frame_error), 32'd0);
    reset = 1'b0;
    step(AN2, 4'h7);
    check("s33_first_new", 32'(new_value), 32'd0);
    check("s33_first_ferr", 32'(frame_error), 32'd0);
    step(AN3, 4'h8);
    idle(3);
    check("s33_partial_value", 32'(value), 32'h0);
    check("s33_partial_valid", 32'(value_valid), 32'd0);
    check("s33_ferr_cnt", 32'(ferr_cnt), 32'd2);
    drain(0);

    // STABLE_FRAMES=1 instance tracks every alternating frame.
    reset = 1'b1;
    rst1  = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      exp1_q.push_back(alt[i]);
      send_frame(alt[i], 1);
      idle(3);
      check("s34_value", 32'(value1), 32'(alt[i]));
      check("s34_valid", 32'(valid1), 32'd1);
      drain(1);
    end
    check("s34_pending", 32'(exp1_q.size()), 32'd0);
    check("s34_ferr_cnt", 32'(ferr1_cnt), 32'd0);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
